// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core (fetch + data ports), the arbiter and the
// external single-port memory. The slave view belongs to the arbiter. The
// master view belongs to whatever drives the core requests and models the
// memory.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MODE_W = 2
);
    // instruction-fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    // data-access port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MODE_W-1:0] d_mode;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    // shared completion qualifier
    logic              err;

    // memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MODE_W-1:0] mem_mode;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ready,
        input  d_req, d_we, d_addr, d_wdata, d_mode,
        output d_rdata, d_ready,
        output err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mode,
        input  mem_ack, mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ready,
        output d_req, d_we, d_addr, d_wdata, d_mode,
        input  d_rdata, d_ready,
        input  err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mode,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between the instruction
// fetch port and the data port of the core. Data has fixed priority over
// fetch. A starvation counter forces a fetch grant after STARVE_LIMIT
// consecutive data grants made while a fetch was waiting. The granted request
// is latched onto the memory bus and held until mem_ack arrives or the
// watchdog expires.
//
// Completion (ready/err/rdata) is combinational from mem_ack so the core can
// continue in the same cycle the memory answers. The memory-side outputs are
// all registered.
module unified_mem_arbiter #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                MODE_W         = 2,
    parameter logic [MODE_W-1:0] MODE_WORD      = 2'b10,
    parameter int                STARVE_LIMIT   = 4,
    parameter int                TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    unified_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } state_t;

    // Watchdog counter sizing. It only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int               TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int               TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_LAST_I);
    localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

    state_t              state_r;
    logic [3:0]          starve_cnt_r;
    logic [TO_W-1:0]     to_cnt_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [MODE_W-1:0]   mem_mode_r;

    logic                grant_i_s;
    logic                grant_d_s;
    logic                timeout_s;
    logic                done_s;
    logic                i_ready_s;
    logic                d_ready_s;
    logic                err_s;
    logic [DATA_W-1:0]   i_rdata_s;
    logic [DATA_W-1:0]   d_rdata_s;

    // Grant decision in IDLE: data first unless the waiting fetch has hit its starvation limit.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == IDLE) begin
            if (bus.d_req && bus.i_req && (starve_cnt_r == STARVE_MAX)) begin
                grant_i_s = 1'b1;
            end else if (bus.d_req) begin
                grant_d_s = 1'b1;
            end else if (bus.i_req) begin
                grant_i_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
                grant_d_s = 1'b0;
            end
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
    end

    // Watchdog expiry and completion detection; a real mem_ack always wins over the timeout.
    always_comb begin
        timeout_s = 1'b0;
        done_s    = 1'b0;
        if (state_r != IDLE) begin
            timeout_s = TO_EN && !bus.mem_ack && (to_cnt_r == TO_LAST);
            done_s    = bus.mem_ack || timeout_s;
        end else begin
            timeout_s = 1'b0;
            done_s    = 1'b0;
        end
    end

    // Completion outputs towards the core, steered to the port that owns the memory.
    always_comb begin
        i_ready_s = 1'b0;
        d_ready_s = 1'b0;
        err_s     = 1'b0;
        i_rdata_s = '0;
        d_rdata_s = '0;
        case (state_r)
            IDLE: begin
                i_ready_s = 1'b0;
                d_ready_s = 1'b0;
            end
            I_WAIT: begin
                i_ready_s = done_s;
                err_s     = timeout_s;
                if (bus.mem_ack) begin
                    i_rdata_s = bus.mem_rdata;
                end else begin
                    i_rdata_s = '0;
                end
            end
            D_WAIT: begin
                d_ready_s = done_s;
                err_s     = timeout_s;
                if (bus.mem_ack) begin
                    d_rdata_s = bus.mem_rdata;
                end else begin
                    d_rdata_s = '0;
                end
            end
            default: begin
                i_ready_s = 1'b0;
                d_ready_s = 1'b0;
                err_s     = 1'b0;
            end
        endcase
    end

    // Arbitration FSM: latch the granted request onto the memory bus, hold it, release on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            starve_cnt_r <= 4'd0;
            to_cnt_r     <= '0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_mode_r   <= MODE_WORD;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        state_r     <= D_WAIT;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= bus.d_we;
                        mem_addr_r  <= bus.d_addr;
                        mem_wdata_r <= bus.d_wdata;
                        mem_mode_r  <= bus.d_mode;
                        to_cnt_r    <= '0;
                        // Count only data grants that actually made a fetch wait.
                        if (bus.i_req) begin
                            if (starve_cnt_r != STARVE_MAX) begin
                                starve_cnt_r <= starve_cnt_r + 4'd1;
                            end
                        end else begin
                            starve_cnt_r <= 4'd0;
                        end
                    end else if (grant_i_s) begin
                        state_r      <= I_WAIT;
                        mem_req_r    <= 1'b1;
                        mem_we_r     <= 1'b0;
                        mem_addr_r   <= bus.i_addr;
                        mem_mode_r   <= MODE_WORD;
                        to_cnt_r     <= '0;
                        starve_cnt_r <= 4'd0;
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                I_WAIT, D_WAIT: begin
                    if (done_s) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end else if (TO_EN && (to_cnt_r != TO_LAST)) begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_mode  = mem_mode_r;

    assign bus.i_ready   = i_ready_s;
    assign bus.i_rdata   = i_rdata_s;
    assign bus.d_ready   = d_ready_s;
    assign bus.d_rdata   = d_rdata_s;
    assign bus.err       = err_s;

endmodule
